// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared 7-segment types and active-low glyph table
package hex_display_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;

    // Active-low glyphs 0-9, A, b, C, d, E, F; bit 0 = a, bit 6 = g
    localparam seg7_t SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_seg_decoder.sv
// rtl/hex_seg_decoder.sv - combinational hex digit to 7-segment decoder with blank and polarity
module hex_seg_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] num_i,
    input  logic       blank_i,
    input  logic       active_low_i,
    output seg7_t      seg_o
);

    seg7_t glyph;
    seg7_t seg_al;

    always_comb begin
        glyph = SEG_BLANK;
        case (num_i)
            4'h0: glyph = SEG_LUT[0];
            4'h1: glyph = SEG_LUT[1];
            4'h2: glyph = SEG_LUT[2];
            4'h3: glyph = SEG_LUT[3];
            4'h4: glyph = SEG_LUT[4];
            4'h5: glyph = SEG_LUT[5];
            4'h6: glyph = SEG_LUT[6];
            4'h7: glyph = SEG_LUT[7];
            4'h8: glyph = SEG_LUT[8];
            4'h9: glyph = SEG_LUT[9];
            4'hA: glyph = SEG_LUT[10];
            4'hB: glyph = SEG_LUT[11];
            4'hC: glyph = SEG_LUT[12];
            4'hD: glyph = SEG_LUT[13];
            4'hE: glyph = SEG_LUT[14];
            4'hF: glyph = SEG_LUT[15];
            default: glyph = SEG_BLANK;
        endcase
    end

    always_comb begin
        seg_al = blank_i ? SEG_BLANK : glyph;
        // Inverting after blanking keeps blank = all segments off in both polarities
        seg_o  = active_low_i ? seg_al : ~seg_al;
    end

endmodule

// File: rtl/display_num_on_hex.sv
// rtl/display_num_on_hex.sv - registered hex digit display; DISPLAY_NUM_ON_HEX_BLINK_EN adds blink
module display_num_on_hex
    import hex_display_pkg::*;
#(
    parameter int ACTIVE_LOW = 1,
    parameter int BLINK_DIV  = 24
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] num,
    input  logic       blank,
`ifdef DISPLAY_NUM_ON_HEX_BLINK_EN
    input  logic       blink,
`endif
    output logic [6:0] HEX
);

    localparam logic  POL_LOW   = (ACTIVE_LOW != 0);
    localparam seg7_t SEG_RESET = POL_LOW ? SEG_BLANK : ~SEG_BLANK;

    seg7_t hex_d;
    seg7_t hex_q;
    logic  blank_eff;

`ifdef DISPLAY_NUM_ON_HEX_BLINK_EN
    logic [BLINK_DIV:0] cnt_d;
    logic [BLINK_DIV:0] cnt_q;

    assign cnt_d     = cnt_q + 1'b1;
    // Top counter bit is the off half of the blink period
    assign blank_eff = blank | (blink & cnt_q[BLINK_DIV]);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign blank_eff = blank;
`endif

    hex_seg_decoder u_dec (
        .num_i        (num),
        .blank_i      (blank_eff),
        .active_low_i (POL_LOW),
        .seg_o        (hex_d)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hex_q <= SEG_RESET;
        end else begin
            hex_q <= hex_d;
        end
    end

    assign HEX = hex_q;

endmodule

// File: tb/tb_display_num_on_hex.sv
// tb/tb_display_num_on_hex.sv - self-checking bench for display_num_on_hex, both polarities
module tb_display_num_on_hex;

    localparam int BD = 2;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] num;
    logic       blank;
    logic       blink;
    logic [6:0] hex_al;
    logic [6:0] hex_ah;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    display_num_on_hex #(.ACTIVE_LOW(1), .BLINK_DIV(BD)) dut_al (
        .clock   (clock),
        .reset_n (reset_n),
        .num     (num),
        .blank   (blank),
`ifdef DISPLAY_NUM_ON_HEX_BLINK_EN
        .blink   (blink),
`endif
        .HEX     (hex_al)
    );

    display_num_on_hex #(.ACTIVE_LOW(0), .BLINK_DIV(BD)) dut_ah (
        .clock   (clock),
        .reset_n (reset_n),
        .num     (num),
        .blank   (blank),
`ifdef DISPLAY_NUM_ON_HEX_BLINK_EN
        .blink   (blink),
`endif
        .HEX     (hex_ah)
    );

    // Reference glyphs (active-low), indexed by digit
    logic [6:0] glyphs [16];
    initial begin
        glyphs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    end

    logic [6:0] exp_al;
    logic [6:0] exp_ah;
    bit         model_valid = 1'b0;
    longint     run_cycles  = 0;

    always @(posedge clock) begin
        logic off;
        if (!reset_n) begin
            exp_al     = 7'h7F;
            run_cycles = 0;
        end else begin
            off = blank;
`ifdef DISPLAY_NUM_ON_HEX_BLINK_EN
            if (blink && (((run_cycles >> BD) & 1) == 1)) off = 1'b1;
`endif
            exp_al     = off ? 7'h7F : glyphs[num];
            run_cycles = run_cycles + 1;
        end
        exp_ah      = ~exp_al;
        model_valid = 1'b1;
    end

    always @(negedge clock) begin
        if (model_valid) begin
            checks++;
            if (hex_al !== exp_al) begin
                errors++;
                $display("FAIL model_al t=%0t HEX=%b expected=%b", $time, hex_al, exp_al);
            end
            checks++;
            if (hex_ah !== exp_ah) begin
                errors++;
                $display("FAIL model_ah t=%0t HEX=%b expected=%b", $time, hex_ah, exp_ah);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic expect_hex(input string name, input logic [6:0] act, input logic [6:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s HEX=%b expected=%b", name, act, req);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        num     = 4'h8;
        blank   = 1'b0;
        blink   = 1'b0;

        tick();
        expect_hex("reset_c1", hex_al, 7'b1111111);
        tick();
        expect_hex("reset_c2", hex_al, 7'b1111111);
        expect_hex("reset_ah", hex_ah, 7'b0000000);
        reset_n = 1'b1;
        tick();
        expect_hex("release_8", hex_al, 7'b0000000);

        for (int i = 0; i < 16; i++) begin
            num = 4'(i);
            tick();
            if (i == 10) expect_hex("sweep_A", hex_al, 7'b0001000);
            if (i == 13) expect_hex("sweep_d", hex_al, 7'b0100001);
        end

        num   = 4'h3;
        blank = 1'b1;
        tick();
        expect_hex("blank_3", hex_al, 7'b1111111);
        expect_hex("blank_3_ah", hex_ah, 7'b0000000);
        blank = 1'b0;
        tick();
        expect_hex("unblank_3", hex_al, 7'b0110000);

        num = {3'b000, 1'b1};
        tick();
        expect_hex("bit1_one", hex_al, 7'b1111001);
        num = {3'b000, 1'b0};
        tick();
        expect_hex("bit1_zero", hex_al, 7'b1000000);

        num = 4'h1;
        tick();
        expect_hex("pol_1", hex_ah, 7'b0000110);
        reset_n = 1'b0;
        tick();
        expect_hex("pol_reset", hex_ah, 7'b0000000);

`ifdef DISPLAY_NUM_ON_HEX_BLINK_EN
        num   = 4'h5;
        blink = 1'b1;
        reset_n = 1'b1;
        for (int j = 0; j < 16; j++) begin
            tick();
            expect_hex("blink_cycle", hex_al, ((j / 4) % 2 == 0) ? 7'b0010010 : 7'b1111111);
        end
        blink = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            expect_hex("blink_off", hex_al, 7'b0010010);
        end
`endif

        reset_n = 1'b1;
        for (int r = 0; r < 400; r++) begin
            num     = 4'($urandom_range(0, 15));
            blank   = ($urandom_range(0, 3) == 0);
            blink   = $urandom_range(0, 1) == 1;
            reset_n = ($urandom_range(0, 24) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
